// File: rtl/cpu_bus_interface_pkg.sv
// Shared encodings for the CPU IO controller handshake and the external bus FSM.
package cpu_bus_interface_pkg;

  localparam int unsigned IO_STATE_W  = 3;
  localparam int unsigned BUS_STATE_W = 2;

  typedef enum logic [IO_STATE_W-1:0] {
    IO_IDLE        = 3'd0,
    IO_READ_BEGIN  = 3'd1,
    IO_READ_WAIT   = 3'd2,
    IO_WRITE_BEGIN = 3'd3,
    IO_WRITE_WAIT  = 3'd4
  } io_state_e;

  typedef enum logic [BUS_STATE_W-1:0] {
    B_IDLE = 2'd0,
    B_REQ  = 2'd1,
    B_DONE = 2'd2
  } bus_state_e;

  function automatic logic is_begin(input logic [IO_STATE_W-1:0] s);
    return (s == IO_READ_BEGIN) || (s == IO_WRITE_BEGIN);
  endfunction

endpackage

// File: rtl/cpu_bus_interface_timeout_counter.sv
// Counts request cycles without ack; flags the last allowed cycle. TIMEOUT=0 never expires.
module cpu_bus_interface_timeout_counter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired_c
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  logic [CNT_W-1:0] count;

  // Saturating so a disabled timeout can sit in B_REQ indefinitely without wrapping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired_c = (TIMEOUT != 0) && (count == CNT_LAST);

endmodule

// File: rtl/cpu_bus_interface.sv
// Bridges IO controller begin/wait states onto a req/ack memory bus with timeout.
module cpu_bus_interface
  import cpu_bus_interface_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        io_state,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              ready,
  output logic              bus_error,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_req,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  bus_state_e        state, state_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_wdata_nxt, cpu_rdata_nxt;
  logic              mem_req_nxt, mem_we_nxt, ready_nxt, bus_error_nxt;
  logic              cnt_clear_c, cnt_enable_c, expired_c;

  cpu_bus_interface_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .clear     (cnt_clear_c),
    .enable    (cnt_enable_c),
    .expired_c (expired_c)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= B_IDLE;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rdata <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      ready     <= 1'b0;
      bus_error <= 1'b0;
    end else begin
      state     <= state_nxt;
      mem_addr  <= mem_addr_nxt;
      mem_wdata <= mem_wdata_nxt;
      cpu_rdata <= cpu_rdata_nxt;
      mem_req   <= mem_req_nxt;
      mem_we    <= mem_we_nxt;
      ready     <= ready_nxt;
      bus_error <= bus_error_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      B_IDLE:  if (is_begin(io_state)) state_nxt = B_REQ;
      B_REQ:   if (mem_ack || expired_c) state_nxt = B_DONE;
      B_DONE:  state_nxt = B_IDLE;
      default: state_nxt = B_IDLE;
    endcase
  end

  // Next register values; ready/bus_error default low so they pulse for one cycle.
  always_comb begin
    mem_addr_nxt  = mem_addr;
    mem_wdata_nxt = mem_wdata;
    cpu_rdata_nxt = cpu_rdata;
    mem_req_nxt   = mem_req;
    mem_we_nxt    = mem_we;
    ready_nxt     = 1'b0;
    bus_error_nxt = 1'b0;
    cnt_clear_c   = 1'b0;
    cnt_enable_c  = 1'b0;
    unique case (state)
      B_IDLE: begin
        if (io_state == IO_READ_BEGIN) begin
          mem_addr_nxt = cpu_addr;
          mem_we_nxt   = 1'b0;
          mem_req_nxt  = 1'b1;
          cnt_clear_c  = 1'b1;
        end else if (io_state == IO_WRITE_BEGIN) begin
          mem_addr_nxt  = cpu_addr;
          mem_wdata_nxt = cpu_wdata;
          mem_we_nxt    = 1'b1;
          mem_req_nxt   = 1'b1;
          cnt_clear_c   = 1'b1;
        end
      end
      B_REQ: begin
        if (mem_ack) begin
          mem_req_nxt = 1'b0;
          ready_nxt   = 1'b1;
          if (!mem_we) cpu_rdata_nxt = mem_rdata;
        end else if (expired_c) begin
          mem_req_nxt   = 1'b0;
          ready_nxt     = 1'b1;
          bus_error_nxt = 1'b1;
          if (!mem_we) cpu_rdata_nxt = '0;
        end else begin
          cnt_enable_c = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_bus_interface.sv
// Directed checks of cpu_bus_interface with TIMEOUT=4.
module tb_cpu_bus_interface;
  import cpu_bus_interface_pkg::*;

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned TIMEOUT = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [2:0]        io_state;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              ready;
  logic              bus_error;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  int errors = 0;
  int checks = 0;

  cpu_bus_interface #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .io_state  (io_state),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .ready     (ready),
    .bus_error (bus_error),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int req_cycles;
  int n;

  initial begin
    reset     = 1'b0;
    io_state  = IO_IDLE;
    cpu_addr  = '0;
    cpu_wdata = '0;
    mem_rdata = '0;
    mem_ack   = 1'b0;
    tick();
    tick();
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_err", 32'(bus_error), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_rdata", 32'(cpu_rdata), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    reset = 1'b1;
    tick();

    // Read, ack on the 3rd request cycle
    io_state = IO_READ_BEGIN;
    cpu_addr = 16'h0040;
    tick();
    io_state = IO_READ_WAIT;
    check("rd_req1", 32'(mem_req), 32'd1);
    check("rd_addr", 32'(mem_addr), 32'h0040);
    check("rd_we", 32'(mem_we), 32'd0);
    check("rd_ready_early1", 32'(ready), 32'd0);
    tick();
    check("rd_req2", 32'(mem_req), 32'd1);
    tick();
    check("rd_req3", 32'(mem_req), 32'd1);
    check("rd_ready_early3", 32'(ready), 32'd0);
    mem_ack   = 1'b1;
    mem_rdata = 16'hBEEF;
    tick();
    mem_ack = 1'b0;
    check("rd_ready", 32'(ready), 32'd1);
    check("rd_req_drop", 32'(mem_req), 32'd0);
    check("rd_rdata", 32'(cpu_rdata), 32'hBEEF);
    check("rd_err", 32'(bus_error), 32'd0);
    tick();
    io_state = IO_IDLE;
    check("rd_ready_pulse", 32'(ready), 32'd0);
    tick();

    // Write, ack in the first request cycle
    io_state  = IO_WRITE_BEGIN;
    cpu_addr  = 16'h1234;
    cpu_wdata = 16'h00A5;
    tick();
    io_state = IO_WRITE_WAIT;
    check("wr_req", 32'(mem_req), 32'd1);
    check("wr_we", 32'(mem_we), 32'd1);
    check("wr_addr", 32'(mem_addr), 32'h1234);
    check("wr_wdata", 32'(mem_wdata), 32'h00A5);
    mem_ack   = 1'b1;
    mem_rdata = 16'h5555;
    tick();
    mem_ack = 1'b0;
    check("wr_ready", 32'(ready), 32'd1);
    check("wr_err", 32'(bus_error), 32'd0);
    check("wr_rdata_kept", 32'(cpu_rdata), 32'hBEEF);
    tick();
    io_state = IO_IDLE;
    check("wr_ready_pulse", 32'(ready), 32'd0);
    tick();

    // Read with no ack times out after exactly TIMEOUT request cycles
    io_state = IO_READ_BEGIN;
    cpu_addr = 16'h0300;
    tick();
    io_state   = IO_READ_WAIT;
    req_cycles = 0;
    n          = 0;
    while (mem_req && n < 20) begin
      req_cycles++;
      n++;
      tick();
    end
    check("to_req_cycles", 32'(req_cycles), 32'd4);
    check("to_ready", 32'(ready), 32'd1);
    check("to_err", 32'(bus_error), 32'd1);
    check("to_rdata", 32'(cpu_rdata), 32'd0);
    tick();
    io_state = IO_IDLE;
    check("to_ready_pulse", 32'(ready), 32'd0);
    check("to_err_pulse", 32'(bus_error), 32'd0);
    tick();

    // Reset asserted on the 2nd request cycle
    io_state = IO_READ_BEGIN;
    cpu_addr = 16'h0050;
    tick();
    io_state = IO_READ_WAIT;
    tick();
    check("rm_req2", 32'(mem_req), 32'd1);
    reset = 1'b0;
    tick();
    check("rm_req_drop", 32'(mem_req), 32'd0);
    check("rm_ready", 32'(ready), 32'd0);
    check("rm_addr", 32'(mem_addr), 32'd0);
    reset    = 1'b1;
    io_state = IO_IDLE;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rm_no_ready", 32'(ready), 32'd0);
    end
    io_state = IO_READ_BEGIN;
    cpu_addr = 16'h0077;
    tick();
    io_state = IO_READ_WAIT;
    check("rm2_addr", 32'(mem_addr), 32'h0077);
    mem_ack   = 1'b1;
    mem_rdata = 16'h1111;
    tick();
    mem_ack = 1'b0;
    check("rm2_ready", 32'(ready), 32'd1);
    check("rm2_rdata", 32'(cpu_rdata), 32'h1111);
    tick();
    io_state = IO_IDLE;
    tick();

    // Stray ack, wait code and undefined code while idle
    for (int i = 0; i < 6; i++) begin
      mem_ack  = (i < 2);
      io_state = (i < 2) ? 3'(IO_IDLE) : (i < 4) ? 3'(IO_READ_WAIT) : 3'b111;
      tick();
      check("idle_no_req", 32'(mem_req), 32'd0);
      check("idle_no_ready", 32'(ready), 32'd0);
    end
    mem_ack  = 1'b0;
    io_state = IO_IDLE;
    tick();

    // Back-to-back read then write
    io_state = IO_READ_BEGIN;
    cpu_addr = 16'h0100;
    tick();
    io_state  = IO_READ_WAIT;
    mem_ack   = 1'b1;
    mem_rdata = 16'hCAFE;
    tick();
    mem_ack = 1'b0;
    check("bb_rd_ready", 32'(ready), 32'd1);
    check("bb_rd_rdata", 32'(cpu_rdata), 32'hCAFE);
    check("bb_gap1", 32'(mem_req), 32'd0);
    tick();
    io_state = IO_IDLE;
    check("bb_gap2", 32'(mem_req), 32'd0);
    io_state  = IO_WRITE_BEGIN;
    cpu_addr  = 16'h0200;
    cpu_wdata = 16'h7E57;
    tick();
    io_state = IO_WRITE_WAIT;
    check("bb_wr_req", 32'(mem_req), 32'd1);
    check("bb_wr_addr", 32'(mem_addr), 32'h0200);
    check("bb_wr_wdata", 32'(mem_wdata), 32'h7E57);
    mem_ack   = 1'b1;
    mem_rdata = 16'h0BAD;
    tick();
    mem_ack = 1'b0;
    check("bb_wr_ready", 32'(ready), 32'd1);
    check("bb_wr_rdata_kept", 32'(cpu_rdata), 32'hCAFE);
    tick();
    io_state = IO_IDLE;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu_bus_interface.md
Name: cpu_bus_interface

Overview:
Downstream of the CPU IO controller. Consumes the 3-bit io_state and drives an external req/ack memory bus: latches the address and write data, holds the request until acknowledged or timed out, and captures read data. Returns a one-cycle ready pulse, which lets the IO controller leave its wait states. Also reports a bus error on timeout.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data width
TIMEOUT, 255, cycles with no ack before the transaction aborts; 0 disables the timeout

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset (0 = reset), sampled on rising clk
io_state  input  3  IO controller state (io_idle/io_read_begin/io_read_wait/io_write_begin/io_write_wait)
cpu_addr  input  ADDR_W  transaction address, valid in the *_begin cycle
cpu_wdata  input  DATA_W  store data, valid in the io_write_begin cycle
cpu_rdata  output  DATA_W  last read data, held until the next read completes
ready  output  1  one-cycle completion pulse to the IO controller
bus_error  output  1  high with ready when the transaction timed out
mem_addr  output  ADDR_W  latched bus address
mem_wdata  output  DATA_W  latched bus write data
mem_req  output  1  bus request, held until ack or timeout
mem_we  output  1  1 = write, 0 = read; valid while mem_req=1
mem_rdata  input  DATA_W  bus read data, valid with mem_ack
mem_ack  input  1  bus acknowledge, single-cycle or level

Behaviour:
- Reset (reset=0 at a clk edge): state B_IDLE. mem_req, mem_we, ready, bus_error = 0. mem_addr, mem_wdata, cpu_rdata = 0. Timeout counter = 0.
- Reset takes priority over all events. Reset mid-transaction drops mem_req at that edge and produces no ready pulse.
- FSM states: B_IDLE, B_REQ, B_DONE.
- B_IDLE:
  - io_state==io_read_begin: latch cpu_addr; mem_we<=0, mem_req<=1, counter<=0; go to B_REQ.
  - io_state==io_write_begin: latch cpu_addr and cpu_wdata; mem_we<=1, mem_req<=1, counter<=0; go to B_REQ.
  - Any other io_state, including undefined codes: stay idle.
  - mem_ack seen in B_IDLE is ignored.
- B_REQ (mem_req=1; mem_addr, mem_wdata, mem_we held stable):
  - mem_ack=1: mem_req<=0; ready<=1; bus_error<=0. On a read, cpu_rdata<=mem_rdata; on a write, cpu_rdata is unchanged. Go to B_DONE.
  - Otherwise, TIMEOUT!=0 and counter==TIMEOUT-1: mem_req<=0; ready<=1; bus_error<=1. On a read, cpu_rdata<=0. Go to B_DONE.
  - Otherwise: counter<=counter+1. The counter is wide enough to hold TIMEOUT and never wraps.
  - An ack in the first B_REQ cycle counts.
- B_DONE: ready<=0, bus_error<=0; go to B_IDLE.
  - ready is high for exactly one cycle, while the IO controller is in *_wait. The controller returns to io_idle on the following edge.
  - A *_begin arriving in B_DONE is not accepted. The IO controller cannot issue one there.
- Latency, begin to ready: begin cycle N gives mem_req=1 from N+1. Ack at cycle N+k (k>=1) gives ready=1 in cycle N+k+1.
- Timeout latency: mem_req stays high for exactly TIMEOUT cycles; ready rises in the next cycle.
- mem_req is never reasserted in the cycle after it drops; there is at least one idle cycle between transactions.
- All outputs are registered, with no combinational path from inputs to outputs.

Decomposition:
- Bus FSM state codes (B_IDLE/B_REQ/B_DONE) go as `define constants in the shared type.v, next to the existing io_* and cpu_* state codes.
- io_* encodings come from type.v; none are redefined locally.
- One sub-module is natural: bus_timeout_counter, holding the clear, enable and expired logic, parameterised by TIMEOUT.

Test Plan:
- Read, ack after 3 cycles: io_read_begin with cpu_addr=16'h0040; mem_ack=1 and mem_rdata=16'hBEEF on the 3rd mem_req cycle -> mem_addr=16'h0040, mem_we=0; ready=1 for one cycle; cpu_rdata=16'hBEEF; bus_error=0.
- Write, immediate ack: io_write_begin with addr 16'h1234 and data 16'h00A5; ack on the first mem_req cycle -> mem_we=1, mem_wdata=16'h00A5; ready the next cycle; cpu_rdata unchanged.
- Timeout with TIMEOUT=4 and no ack -> mem_req high exactly 4 cycles, then ready=1 and bus_error=1 for one cycle; a read returns cpu_rdata=0.
- Reset mid-transaction: reset=0 on the 2nd mem_req cycle -> mem_req=0 at that edge; no ready pulse; the next read works normally.
- Stray ack and idle codes: mem_ack pulses while in B_IDLE, io_state=io_read_wait in B_IDLE, and undefined code 3'b111 -> no mem_req, no ready.
- Back-to-back transactions: a read, then a write issued as soon as the IO controller returns to idle -> the mem_req pulses are separated by at least one low cycle; both complete with correct data.
